// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types and helpers for the pipeline hazard unit
package arm_pkg;

    localparam int MAX_AW  = 8;
    localparam int MAX_SRC = 3;

    typedef logic [MAX_AW-1:0] reg_addr_t;

    localparam reg_addr_t PC_REG = reg_addr_t'(15);

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                      valid;
        reg_addr_t                 dst;
        logic                      reg_write;
        logic                      mem_to_reg;
        reg_addr_t [MAX_SRC-1:0]   src;
        logic      [MAX_SRC-1:0]   src_used;
    } hz_entry_t;

    // A producer entry satisfies a consumer source; r15 is never matched.
    function automatic logic hz_match(hz_entry_t p, reg_addr_t src, logic used);
        return p.valid && p.reg_write && used && (p.dst == src) && (src != PC_REG);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - tracking pipe of in-flight instructions, E through W
module hazard_scoreboard
    import arm_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_load,
    input  hz_entry_t                 i_d_entry,
    output hz_entry_t [MEM_LAT+1:0]   o_pipe
);

    // Index 0 is E, 1..MEM_LAT are M1..M{MEM_LAT}, MEM_LAT+1 is W.
    hz_entry_t [MEM_LAT+1:0] r_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_load ? i_d_entry : '0;
            for (int k = 1; k <= MEM_LAT + 1; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign o_pipe = r_pipe;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, PC-write flush and operand forwarding control
module hazard_unit
    import arm_pkg::*;
#(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 2,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dec_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   dec_src,
    input  logic [NUM_SRC-1:0]          dec_src_used,
    input  logic [REG_AW-1:0]           dec_dst,
    input  logic                        dec_reg_write,
    input  logic                        dec_mem_to_reg,
    input  logic                        branch_taken_e,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        stall_f,
    output logic                        stall_d,
    output logic                        flush_d,
    output logic                        flush_e,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);

    localparam int W_IDX = MEM_LAT + 1;

    hz_entry_t              w_d_entry;
    hz_entry_t [W_IDX:0]    w_pipe;
    logic                   w_ld_stall;
    logic                   w_pc_pend;
    logic                   w_w_pc;
    logic                   w_flush_e_raw;
    logic [2*NUM_SRC-1:0]   w_fwd;
    logic [CNT_W-1:0]       r_stall_cnt;
    logic [CNT_W-1:0]       r_flush_cnt;
    logic                   w_unused;

    always_comb begin
        w_d_entry            = '0;
        w_d_entry.valid      = dec_valid;
        w_d_entry.dst        = reg_addr_t'(dec_dst);
        w_d_entry.reg_write  = dec_reg_write;
        w_d_entry.mem_to_reg = dec_mem_to_reg;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_d_entry.src[i]      = reg_addr_t'(dec_src[i*REG_AW +: REG_AW]);
            w_d_entry.src_used[i] = dec_src_used[i];
        end
    end

    hazard_scoreboard #(
        .MEM_LAT   (MEM_LAT)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .i_load    (dec_valid & ~w_flush_e_raw),
        .i_d_entry (w_d_entry),
        .o_pipe    (w_pipe)
    );

    // Load data is not available until the last M stage, so earlier loads stall D.
    always_comb begin
        w_ld_stall = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                if (dec_valid && w_pipe[k].mem_to_reg &&
                    hz_match(w_pipe[k], w_d_entry.src[s], w_d_entry.src_used[s])) begin
                    w_ld_stall = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_pc_pend = dec_valid && dec_reg_write && (w_d_entry.dst == PC_REG);
        for (int k = 0; k <= MEM_LAT; k++) begin
            if (w_pipe[k].valid && w_pipe[k].reg_write && (w_pipe[k].dst == PC_REG)) begin
                w_pc_pend = 1'b1;
            end
        end
    end

    assign w_w_pc = w_pipe[W_IDX].valid && w_pipe[W_IDX].reg_write &&
                    (w_pipe[W_IDX].dst == PC_REG);

    // A load sitting in M1 is excluded here; ld_stall keeps its consumer out of E.
    always_comb begin
        w_fwd = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (hz_match(w_pipe[1], w_pipe[0].src[s], w_pipe[0].src_used[s]) &&
                !w_pipe[1].mem_to_reg) begin
                w_fwd[2*s +: 2] = FWD_M;
            end else if (hz_match(w_pipe[W_IDX], w_pipe[0].src[s], w_pipe[0].src_used[s])) begin
                w_fwd[2*s +: 2] = FWD_W;
            end
        end
    end

    assign w_flush_e_raw = w_ld_stall | branch_taken_e;

    assign stall_d = ~reset & w_ld_stall;
    assign stall_f = ~reset & (w_ld_stall | w_pc_pend);
    assign flush_e = ~reset & w_flush_e_raw;
    assign flush_d = ~reset & (w_pc_pend | branch_taken_e | w_w_pc);
    assign fwd_sel = reset ? '0 : w_fwd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_f && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if ((flush_d | flush_e) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // Sources of older entries and padding bits are carried but not consulted.
    assign w_unused = ^w_pipe;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit at MEM_LAT=1 and MEM_LAT=3
module tb_hazard_unit;

    localparam int AW = 4;
    localparam int NS = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              dec_valid;
    logic [NS*AW-1:0]  dec_src;
    logic [NS-1:0]     dec_src_used;
    logic [AW-1:0]     dec_dst;
    logic              dec_reg_write;
    logic              dec_mem_to_reg;
    logic              branch_taken_e;

    logic [2*NS-1:0]   fwd1, fwd3;
    logic              sf1, sd1, fd1, fe1;
    logic              sf3, sd3, fd3, fe3;
    logic [15:0]       sc1, fc1;
    logic [3:0]        sc3, fc3;

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .MEM_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src(dec_src),
        .dec_src_used(dec_src_used), .dec_dst(dec_dst), .dec_reg_write(dec_reg_write),
        .dec_mem_to_reg(dec_mem_to_reg), .branch_taken_e(branch_taken_e),
        .fwd_sel(fwd1), .stall_f(sf1), .stall_d(sd1), .flush_d(fd1), .flush_e(fe1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .MEM_LAT(3), .CNT_W(4)) u_lat3 (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src(dec_src),
        .dec_src_used(dec_src_used), .dec_dst(dec_dst), .dec_reg_write(dec_reg_write),
        .dec_mem_to_reg(dec_mem_to_reg), .branch_taken_e(branch_taken_e),
        .fwd_sel(fwd3), .stall_f(sf3), .stall_d(sd3), .flush_d(fd3), .flush_e(fe3),
        .stall_cnt(sc3), .flush_cnt(fc3)
    );

    typedef struct packed {
        bit v; bit rw; bit ld; bit u0; bit u1;
        int dst; int s0; int s1;
    } ins_t;

    typedef struct packed {
        int fwd; bit sf; bit sd; bit fd; bit fe; int sc; int fc;
    } exp_t;

    // In-flight instructions by age: 0 is E, 1..L are the memory stages, L+1 is W.
    ins_t pipe [2][6];
    int   sc_m [2];
    int   fc_m [2];
    exp_t q1[$];
    exp_t q3[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit writes(ins_t p, int r);
        return p.v && p.rw && (r != 15) && (p.dst == r);
    endfunction

    function automatic int sel(int id, int lat, bit used, int r);
        if (!used) return 0;
        if (writes(pipe[id][1], r) && !pipe[id][1].ld) return 2;
        if (writes(pipe[id][lat+1], r)) return 1;
        return 0;
    endfunction

    task automatic model_step(input int id, input ins_t d, input bit br, input bit rst,
                              output exp_t e);
        int lat = (id == 0) ? 1 : 3;
        int mx  = (id == 0) ? 65535 : 15;
        bit ld, pc, wpc;
        e    = '0;
        e.sc = sc_m[id];
        e.fc = fc_m[id];
        if (rst) begin
            sc_m[id] = 0;
            fc_m[id] = 0;
            for (int a = 0; a < 6; a++) pipe[id][a] = '0;
        end else begin
            ld = 0;
            if (d.v) begin
                for (int a = 0; a < lat; a++) begin
                    if (pipe[id][a].ld && ((d.u0 && writes(pipe[id][a], d.s0)) ||
                                           (d.u1 && writes(pipe[id][a], d.s1)))) ld = 1;
                end
            end
            pc = d.v && d.rw && (d.dst == 15);
            for (int a = 0; a <= lat; a++) begin
                if (pipe[id][a].v && pipe[id][a].rw && pipe[id][a].dst == 15) pc = 1;
            end
            wpc = pipe[id][lat+1].v && pipe[id][lat+1].rw && pipe[id][lat+1].dst == 15;
            e.fwd = sel(id, lat, pipe[id][0].u0, pipe[id][0].s0) +
                    4 * sel(id, lat, pipe[id][0].u1, pipe[id][0].s1);
            e.sd = ld;
            e.sf = ld | pc;
            e.fe = ld | br;
            e.fd = pc | br | wpc;
            if (e.sf && sc_m[id] < mx) sc_m[id]++;
            if ((e.fd || e.fe) && fc_m[id] < mx) fc_m[id]++;
            for (int a = lat + 1; a >= 1; a--) pipe[id][a] = pipe[id][a-1];
            pipe[id][0] = (d.v && !e.fe) ? d : '0;
        end
    endtask

    task automatic drive(input bit v, input int dst, input bit rw, input bit ld,
                         input int s0, input bit u0, input int s1, input bit u1,
                         input bit br, input bit rst);
        ins_t d;
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst;
        dec_valid      = v;
        dec_dst        = AW'(dst);
        dec_reg_write  = rw;
        dec_mem_to_reg = ld;
        dec_src        = {AW'(s1), AW'(s0)};
        dec_src_used   = {u1, u0};
        branch_taken_e = br;
        d     = '0;
        d.v   = v;   d.rw = rw; d.ld = ld; d.dst = dst;
        d.s0  = s0;  d.u0 = u0; d.s1 = s1;  d.u1 = u1;
        model_step(0, d, br, rst, e);
        q1.push_back(e);
        model_step(1, d, br, rst, e);
        q3.push_back(e);
    endtask

    task automatic alu(input int dst, input int s0, input bit u0, input int s1, input bit u1);
        drive(1, dst, 1, 0, s0, u0, s1, u1, 0, 0);
    endtask

    task automatic ldr(input int dst);
        drive(1, dst, 1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    function automatic int rreg();
        if ($urandom_range(0, 7) == 0) return 15;
        return int'($urandom_range(0, 4));
    endfunction

    task automatic cmp(input string tag, input exp_t e, input logic [31:0] fwd,
                       input logic sf, input logic sd, input logic fd, input logic fe,
                       input logic [31:0] sc, input logic [31:0] fc);
        chk({tag, " fwd_sel"},   fwd, e.fwd);
        chk({tag, " stall_f"},   {31'b0, sf}, {31'b0, e.sf});
        chk({tag, " stall_d"},   {31'b0, sd}, {31'b0, e.sd});
        chk({tag, " flush_d"},   {31'b0, fd}, {31'b0, e.fd});
        chk({tag, " flush_e"},   {31'b0, fe}, {31'b0, e.fe});
        chk({tag, " stall_cnt"}, sc, e.sc);
        chk({tag, " flush_cnt"}, fc, e.fc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("lat1", e, 32'(fwd1), sf1, sd1, fd1, fe1, 32'(sc1), 32'(fc1));
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            cmp("lat3", e, 32'(fwd3), sf3, sd3, fd3, fe3, 32'(sc3), 32'(fc3));
        end
    end

    initial begin
        reset = 1'b1; dec_valid = 1'b0; dec_src = '0; dec_src_used = '0; dec_dst = '0;
        dec_reg_write = 1'b0; dec_mem_to_reg = 1'b0; branch_taken_e = 1'b0;
        rst_cyc();
        rst_cyc();

        alu(1, 0, 0, 0, 0); alu(2, 0, 0, 0, 0); alu(3, 4, 1, 0, 0);
        repeat (4) nop();
        @(negedge clk);
        chk("indep stall_cnt", 32'(sc1), 0);
        chk("indep flush_cnt", 32'(fc1), 0);

        alu(2, 0, 0, 0, 0); alu(5, 2, 1, 2, 1); nop();
        @(negedge clk);
        chk("b2b fwd_sel", 32'(fwd1), 32'b1010);
        repeat (3) nop();
        alu(2, 0, 0, 0, 0); nop(); alu(5, 2, 1, 2, 1); nop();
        @(negedge clk);
        chk("gap fwd_sel", 32'(fwd1), 32'b0101);

        rst_cyc();
        ldr(3);
        repeat (3) alu(4, 3, 1, 0, 0);
        @(negedge clk);
        chk("load-use fwd slot0", 32'(fwd1[1:0]), 1);
        alu(4, 3, 1, 0, 0);
        repeat (6) nop();
        @(negedge clk);
        chk("load-use stall_cnt lat1", 32'(sc1), 1);
        chk("load-use stall_cnt lat3", 32'(sc3), 3);

        rst_cyc();
        alu(15, 0, 0, 0, 0);
        repeat (6) nop();
        @(negedge clk);
        chk("pc write stall_cnt lat1", 32'(sc1), 3);
        chk("pc write flush_cnt lat1", 32'(fc1), 4);
        chk("pc write stall_cnt lat3", 32'(sc3), 5);
        chk("pc write flush_cnt lat3", 32'(fc3), 6);

        rst_cyc();
        ldr(3);
        drive(1, 4, 1, 0, 3, 1, 0, 0, 1, 0);
        @(negedge clk);
        chk("br+ld flush_e", {31'b0, fe1}, 1);
        chk("br+ld flush_d", {31'b0, fd1}, 1);
        chk("br+ld stall_d", {31'b0, sd1}, 1);
        repeat (3) nop();

        rst_cyc();
        repeat (20) alu(15, 0, 0, 0, 0);
        @(negedge clk);
        chk("saturated stall_cnt lat3", 32'(sc3), 15);
        drive(1, 15, 1, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("in reset stall_f", {31'b0, sf1}, 0);
        chk("in reset flush_e", {31'b0, fe1}, 0);
        nop();
        @(negedge clk);
        chk("after reset stall_f", {31'b0, sf1}, 0);
        chk("after reset flush_d", {31'b0, fd1}, 0);
        chk("after reset stall_cnt lat1", 32'(sc1), 0);
        chk("after reset stall_cnt lat3", 32'(sc3), 0);

        repeat (600) begin
            drive($urandom_range(0, 3) != 0, rreg(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, rreg(), 1'($urandom), rreg(), 1'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        end

        nop();
        @(negedge clk);
        @(negedge clk);
        chk("drain lat1", q1.size(), 0);
        chk("drain lat3", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
